mcu_channel_writer: RTL and testbench
=====================================

Name: mcu_channel_writer

Overview:
- Writer side of the YCbCr channel buffer.
- Accepts dequantized/IDCT'd 8x8 blocks one at a time, in 4:2:0 MCU order: Y0, Y1, Y2, Y3, Cb, Cr.
- Y blocks are forwarded to the buffer on ch=0 (blocks_out[0] only).
- Cb and Cr are nearest-neighbour upsampled 8x8 -> 16x16, split into 4 quadrant blocks, and written on ch=1 and ch=2.
- Throttles upstream so Y writes of MCU n+1 never race the buffer's 4-cycle drain of MCU n.

Parameters:
- DRAIN_CYCLES, 4, cycles ready_out is held low after a Cr block is accepted (buffer drain length).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- block_in  input  [`Q-1:0][7:0][7:0]  one decoded 8x8 component block
- valid_in  input  1  block_in valid
- ready_out  output  1  writer can accept block_in this cycle
- blocks_out  output  [`Q-1:0][3:0][7:0][7:0]  to channel buffer blocks_in
- wr_en  output  1  channel buffer write strobe
- ch  output  [$clog2(`CH+1)-1:0]  0=Y, 1=Cb, 2=Cr
- mcu_done  output  1  one-cycle pulse coincident with the Cr write

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - wr_en=0, ch=0, mcu_done=0, blocks_out all 0.
  - comp counter=0, drain counter=0, ready_out=1.
- Accept condition: valid_in && ready_out. Block is captured at the rising edge; no other handshake.
- ready_out = (drain == 0). It is combinational from a register and independent of valid_in.
- Latency: exactly 1 cycle. On the cycle after an accept:
  - wr_en=1, ch and blocks_out as below.
  - Otherwise wr_en=0 and blocks_out holds its last value; ch is don't-care when wr_en=0, but the RTL holds it.
- Comp counter (0..5), advancing by 1 per accept and wrapping 5->0:
  - comp 0..3: ch=0. blocks_out[0] = block_in; blocks_out[1..3] = 0.
  - comp 4: ch=1, chroma upsample.
  - comp 5: ch=2, chroma upsample. mcu_done=1 on the write cycle. drain loaded with DRAIN_CYCLES at the accept edge.
- Chroma upsample, quadrant q (0=TL, 1=TR, 2=BL, 3=BR), r,c in 0..7:
  - blocks_out[q][r][c] = block_in[(q>>1)*4 + (r>>1)][(q&1)*4 + (c>>1)].
  - Pure bit copy; no arithmetic or width change.
- Drain counter: decrements by 1 per cycle while nonzero. ready_out returns high on the cycle drain reaches 0. Total stall is DRAIN_CYCLES cycles after the Cr accept.
- Exactly 4 Y writes per MCU are guaranteed, keeping the buffer's 2-bit tail pointer aligned to 0 at each MCU start.
- Gaps in valid_in are legal anywhere in an MCU. The comp counter holds and wr_en stays 0.
- valid_in held high while ready_out=0: no accept, no state change, block_in is ignored.
- Reset mid-MCU: comp, drain, and outputs return to reset values immediately. The next accepted block is treated as Y0. The downstream buffer must be reset together with this block.
- No error outputs. Upstream owns component order.

Decomposition:
- Shared package / sys_defs:
  - CH_Y=0, CH_CB=1, CH_CR=2.
  - MCU_BLOCKS=6, Y_PER_MCU=4.
  - Reuse the existing BLOCK typedef and `Q.
- Sub-module chroma_upsample_420: combinational 8x8 -> [3:0][7:0][7:0] quadrant replication. It is instantiated once and its output is muxed against the Y path before the output register.
- Main module: comp counter, drain counter, output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> outputs immediately 0, ready_out=1. Release; check wr_en stays 0 with valid_in=0.
- Full MCU back-to-back: blocks with every element = 1,2,3,4 (Y), 5 (Cb), 6 (Cr) and valid_in held high.
  - wr_en pulses on 6 consecutive cycles with ch = 0,0,0,0,1,2.
  - blocks_out[0] = 1..4 on the Y writes, blocks_out[1..3]=0.
  - All quadrants = 5 on the Cb write, then = 6 on the Cr write.
  - mcu_done high only on the Cr write.
- Upsample mapping: Cb block with element [r][c] = r*8+c.
  - blocks_out[0][0][0]=0, [0][7][7]=27.
  - [1][0][0]=4, [2][0][0]=32, [3][7][7]=63.
  - [3][1][1]=36.
- Drain stall: valid_in held high across two MCUs.
  - ready_out=0 for exactly 4 cycles after the Cr accept.
  - Next Y0 write occurs 5 cycles after the Cr write.
  - Connected channel buffer emits valid_out for 4 cycles with the correct Y0..Y3 pairing.
- Bubbles: valid_in toggles 1,0,0,1,... through an MCU -> same ch sequence, and wr_en only on the cycle after each accept.
- Reset mid-MCU: reset after the Y2 accept, then send a full MCU -> ch sequence restarts at 0,0,0,0,1,2, and the buffer output matches the new MCU only.

Source files
------------

// File: rtl/mcu_channel_writer_pkg.sv
// Shared types and constants for the YCbCr channel buffer writer.
// A BLOCK is indexed [row][col] and holds Q-bit samples.
package mcu_channel_writer_pkg;

  localparam int Q          = 8;
  localparam int CH         = 3;
  localparam int CHW        = $clog2(CH + 1);
  localparam int MCU_BLOCKS = 6;
  localparam int Y_PER_MCU  = 4;

  localparam logic [CHW-1:0] CH_Y  = CHW'(0);
  localparam logic [CHW-1:0] CH_CB = CHW'(1);
  localparam logic [CHW-1:0] CH_CR = CHW'(2);

  typedef logic [7:0][7:0][Q-1:0] BLOCK;
  typedef BLOCK [3:0] QUAD;

  typedef enum logic [2:0] {
    C_Y0, C_Y1, C_Y2, C_Y3, C_CB, C_CR
  } comp_e;

endpackage

// File: rtl/mcu_channel_writer_upsample.sv
// 4:2:0 chroma upsample: one 8x8 block replicated into four
// 8x8 quadrant blocks of the 16x16 nearest-neighbour image.
module chroma_upsample_420
  import mcu_channel_writer_pkg::*;
(
  input  BLOCK blk_i,
  output QUAD  quad_o
);

  for (genvar q = 0; q < 4; q++) begin : g_q
    for (genvar r = 0; r < 8; r++) begin : g_r
      for (genvar c = 0; c < 8; c++) begin : g_c
        assign quad_o[q][r][c] =
          blk_i[(q >> 1) * 4 + (r >> 1)]
               [(q & 1) * 4 + (c >> 1)];
      end
    end
  end

endmodule

// File: rtl/mcu_channel_writer.sv
// Writer side of the YCbCr channel buffer: registers Y blocks,
// upsamples Cb/Cr, and stalls upstream while the buffer drains.
module mcu_channel_writer
  import mcu_channel_writer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  BLOCK           block_in,
  input  logic           valid_in,
  output logic           ready_out,
  output QUAD            blocks_out,
  output logic           wr_en,
  output logic [CHW-1:0] ch,
  output logic           mcu_done
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  comp_e          comp_q, comp_d;
  logic [DW-1:0]  drain_q, drain_d;
  QUAD            blk_q, blk_d;
  logic           wr_q, wr_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           done_q, done_d;
  QUAD            up;
  logic           accept;

  chroma_upsample_420 u_up (
    .blk_i  (block_in),
    .quad_o (up)
  );

  assign ready_out  = (drain_q == '0);
  assign accept     = valid_in && ready_out;
  assign blocks_out = blk_q;
  assign wr_en      = wr_q;
  assign ch         = ch_q;
  assign mcu_done   = done_q;

  always_comb begin
    comp_d  = comp_q;
    drain_d = drain_q;
    blk_d   = blk_q;
    wr_d    = 1'b0;
    ch_d    = ch_q;
    done_d  = 1'b0;
    if (drain_q != '0) drain_d = drain_q - 1'b1;
    if (accept) begin
      wr_d = 1'b1;
      unique case (comp_q)
        C_Y0, C_Y1, C_Y2, C_Y3: begin
          ch_d     = CH_Y;
          blk_d    = '0;
          blk_d[0] = block_in;
          comp_d   = comp_e'(comp_q + 3'd1);
        end
        C_CB: begin
          ch_d   = CH_CB;
          blk_d  = up;
          comp_d = C_CR;
        end
        C_CR: begin
          // Cr closes the MCU; hold off Y0 until the buffer drains
          ch_d    = CH_CR;
          blk_d   = up;
          done_d  = 1'b1;
          drain_d = DW'(DRAIN_CYCLES);
          comp_d  = C_Y0;
        end
        default: comp_d = C_Y0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_q  <= C_Y0;
      drain_q <= '0;
      blk_q   <= '0;
      wr_q    <= 1'b0;
      ch_q    <= CH_Y;
      done_q  <= 1'b0;
    end else begin
      comp_q  <= comp_d;
      drain_q <= drain_d;
      blk_q   <= blk_d;
      wr_q    <= wr_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mcu_channel_writer.sv
// Bench for mcu_channel_writer: vector table, corner sequences,
// and random traffic against an MCU-level reference model.
module tb_mcu_channel_writer;
  import mcu_channel_writer_pkg::*;

  localparam int DRAIN = 4;

  logic           clk = 1'b0;
  logic           rst;
  BLOCK           block_in;
  logic           valid_in;
  logic           ready_out;
  QUAD            blocks_out;
  logic           wr_en;
  logic [CHW-1:0] ch;
  logic           mcu_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mcu_channel_writer #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .block_in   (block_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .blocks_out (blocks_out),
    .wr_en      (wr_en),
    .ch         (ch),
    .mcu_done   (mcu_done)
  );

  typedef struct {
    logic       v;
    logic [7:0] fill;
    logic       wr;
    logic [1:0] ch;
    logic       done;
    logic       rdy;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tbl[16];

  function automatic BLOCK fill_blk(input logic [7:0] v);
    BLOCK b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = v;
    return b;
  endfunction

  function automatic QUAD quad_fill(input logic [7:0] a,
                                    input logic [7:0] b);
    QUAD o;
    o[0] = fill_blk(a);
    for (int q = 1; q < 4; q++) o[q] = fill_blk(b);
    return o;
  endfunction

  // Expected write payload for the idx-th block of an MCU
  function automatic QUAD model_out(input int idx, input BLOCK b);
    QUAD o = '0;
    if (idx < 4) o[0] = b;
    else
      for (int q = 0; q < 4; q++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            o[q][r][c] = b[(q / 2) * 4 + r / 2][(q % 2) * 4 + c / 2];
    return o;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chkq(input string n, input QUAD act,
                      input QUAD exp);
    bit bad = 0;
    tests++;
    for (int q = 0; q < 4; q++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (!bad && act[q][r][c] !== exp[q][r][c]) begin
            bad = 1;
            $display("FAIL %s: [%0d][%0d][%0d] got %0h expected %0h",
                     n, q, r, c, act[q][r][c], exp[q][r][c]);
          end
    if (bad) fails++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input BLOCK b);
    valid_in = 1'b1;
    block_in = b;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  BLOCK ramp;
  BLOCK rb;
  QUAD  last, expq;
  int   cnt, stall;
  logic v, acc;
  string nm;

  initial begin
    tbl[0]  = '{1'b1, 8'd1,  1'b1, 2'd0, 1'b0, 1'b1, 8'd1,  8'd0};
    tbl[1]  = '{1'b1, 8'd2,  1'b1, 2'd0, 1'b0, 1'b1, 8'd2,  8'd0};
    tbl[2]  = '{1'b1, 8'd3,  1'b1, 2'd0, 1'b0, 1'b1, 8'd3,  8'd0};
    tbl[3]  = '{1'b1, 8'd4,  1'b1, 2'd0, 1'b0, 1'b1, 8'd4,  8'd0};
    tbl[4]  = '{1'b1, 8'd5,  1'b1, 2'd1, 1'b0, 1'b1, 8'd5,  8'd5};
    tbl[5]  = '{1'b1, 8'd6,  1'b1, 2'd2, 1'b1, 1'b0, 8'd6,  8'd6};
    tbl[6]  = '{1'b1, 8'd7,  1'b0, 2'd2, 1'b0, 1'b0, 8'd6,  8'd6};
    tbl[7]  = '{1'b1, 8'd8,  1'b0, 2'd2, 1'b0, 1'b0, 8'd6,  8'd6};
    tbl[8]  = '{1'b1, 8'd9,  1'b0, 2'd2, 1'b0, 1'b0, 8'd6,  8'd6};
    tbl[9]  = '{1'b1, 8'd10, 1'b0, 2'd2, 1'b0, 1'b1, 8'd6,  8'd6};
    tbl[10] = '{1'b1, 8'd11, 1'b1, 2'd0, 1'b0, 1'b1, 8'd11, 8'd0};
    tbl[11] = '{1'b0, 8'd12, 1'b0, 2'd0, 1'b0, 1'b1, 8'd11, 8'd0};
    tbl[12] = '{1'b0, 8'd13, 1'b0, 2'd0, 1'b0, 1'b1, 8'd11, 8'd0};
    tbl[13] = '{1'b1, 8'd14, 1'b1, 2'd0, 1'b0, 1'b1, 8'd14, 8'd0};
    tbl[14] = '{1'b0, 8'd15, 1'b0, 2'd0, 1'b0, 1'b1, 8'd14, 8'd0};
    tbl[15] = '{1'b1, 8'd16, 1'b1, 2'd0, 1'b0, 1'b1, 8'd16, 8'd0};

    rst = 1'b1;
    valid_in = 1'b0;
    block_in = '0;
    #12;
    chk("rst_wr", 32'(wr_en), 0);
    chk("rst_rdy", 32'(ready_out), 1);
    chk("rst_done", 32'(mcu_done), 0);
    chkq("rst_blk", blocks_out, '0);
    @(negedge clk) rst = 1'b0;
    tick();
    tick();
    chk("idle_wr", 32'(wr_en), 0);

    // back-to-back MCU, drain stall, next MCU with bubbles
    for (int i = 0; i < 16; i++) begin
      valid_in = tbl[i].v;
      block_in = fill_blk(tbl[i].fill);
      tick();
      nm = $sformatf("vec%0d", i);
      chk({nm, "_wr"}, 32'(wr_en), 32'(tbl[i].wr));
      chk({nm, "_ch"}, 32'(ch), 32'(tbl[i].ch));
      chk({nm, "_done"}, 32'(mcu_done), 32'(tbl[i].done));
      chk({nm, "_rdy"}, 32'(ready_out), 32'(tbl[i].rdy));
      chkq({nm, "_blk"}, blocks_out,
           quad_fill(tbl[i].e0, tbl[i].e1));
    end
    valid_in = 1'b0;

    // finish MCU, then reset asynchronously in the drain window
    send(fill_blk(8'd17));
    send(fill_blk(8'd18));
    send(fill_blk(8'd19));
    chk("cr2_done", 32'(mcu_done), 1);
    chk("cr2_rdy", 32'(ready_out), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr", 32'(wr_en), 0);
    chk("arst_done", 32'(mcu_done), 0);
    chk("arst_ch", 32'(ch), 0);
    chk("arst_rdy", 32'(ready_out), 1);
    chkq("arst_blk", blocks_out, '0);
    @(negedge clk) rst = 1'b0;

    // upsample index mapping
    for (int i = 0; i < 4; i++) send(fill_blk(8'd0));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) ramp[r][c] = 8'(r * 8 + c);
    send(ramp);
    chk("up_ch", 32'(ch), 1);
    chk("up_0_0_0", 32'(blocks_out[0][0][0]), 0);
    chk("up_0_7_7", 32'(blocks_out[0][7][7]), 27);
    chk("up_1_0_0", 32'(blocks_out[1][0][0]), 4);
    chk("up_2_0_0", 32'(blocks_out[2][0][0]), 32);
    chk("up_3_7_7", 32'(blocks_out[3][7][7]), 63);
    chk("up_3_1_1", 32'(blocks_out[3][1][1]), 36);
    chkq("up_full", blocks_out, model_out(4, ramp));

    // reset after Y2 of a partial MCU restarts at Y0
    pulse_reset();
    for (int i = 0; i < 3; i++) send(fill_blk(8'(8'h21 + i)));
    pulse_reset();
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      block_in = fill_blk(8'(8'h31 + i));
      tick();
      nm = $sformatf("rmid%0d", i);
      chk({nm, "_wr"}, 32'(wr_en), 1);
      chk({nm, "_ch"}, 32'(ch), i < 4 ? 0 : i - 3);
      chk({nm, "_done"}, 32'(mcu_done), i == 5 ? 1 : 0);
      chkq({nm, "_blk"}, blocks_out,
           model_out(i, fill_blk(8'(8'h31 + i))));
    end
    valid_in = 1'b0;

    // random traffic against reference model
    pulse_reset();
    cnt = 0;
    stall = 0;
    last = '0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) rb[r][c] = 8'($urandom);
      valid_in = v;
      block_in = rb;
      chk("rnd_rdy", 32'(ready_out), stall == 0 ? 1 : 0);
      acc = v && (stall == 0);
      tick();
      if (acc) begin
        expq = model_out(cnt, rb);
        chk("rnd_wr", 32'(wr_en), 1);
        chk("rnd_ch", 32'(ch), cnt < 4 ? 0 : cnt - 3);
        chk("rnd_done", 32'(mcu_done), cnt == 5 ? 1 : 0);
        chkq("rnd_blk", blocks_out, expq);
        last = expq;
        if (cnt == 5) stall = DRAIN;
        cnt = (cnt + 1) % 6;
      end else begin
        if (stall > 0) stall--;
        chk("rnd_wr_idle", 32'(wr_en), 0);
        chk("rnd_done_idle", 32'(mcu_done), 0);
        chkq("rnd_blk_hold", blocks_out, last);
      end
    end
    valid_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
